// File: rtl/fifo_pointer_ctrl.sv
// fifo_pointer_ctrl
//
// Single-clock FIFO pointer controller for an external dual-port RAM of 2^ADDR_WIDTH words.
// It sequences a binary write/read pointer pair (one extra wrap bit each) and exports both
// pointers in Gray code, so a later dual-clock FIFO can reuse the same pointer format.
// Full and empty are derived from the next-state Gray pointers and registered, which keeps
// every status output free of combinational paths from the inputs.
//
// Optional feature macro: FIFO_POINTER_CTRL_LEVEL_EN
//   Defined   : o_almostFull / o_almostEmpty are registered threshold flags on the fill level.
//   Undefined : both ports are tied to 0 and ALMOST_FULL / ALMOST_EMPTY are ignored.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_flush        synchronous clear of both pointers (wins over push and pop)
//   i_wrValid      producer offers a word
//   o_wrReady      FIFO can accept a word (not full)
//   o_wrEnable     RAM write strobe for the accepted push
//   o_wrAddr       RAM write address
//   i_rdReady      consumer takes the head word
//   o_rdValid      head word valid (not empty)
//   o_rdAddr       RAM read address of the head word
//   o_wrPtrGray    write pointer, Gray code (ADDR_WIDTH+1 bits)
//   o_rdPtrGray    read pointer, Gray code (ADDR_WIDTH+1 bits)
//   o_count        fill level, 0..2^ADDR_WIDTH
//   o_full         registered full flag
//   o_empty        registered empty flag
//   o_almostFull   fill level >= ALMOST_FULL (optional feature)
//   o_almostEmpty  fill level <= ALMOST_EMPTY (optional feature)

module fifo_pointer_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned ALMOST_FULL  = 12,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_wrValid,
    output logic                  o_wrReady,
    output logic                  o_wrEnable,
    output logic [ADDR_WIDTH-1:0] o_wrAddr,
    input  logic                  i_rdReady,
    output logic                  o_rdValid,
    output logic [ADDR_WIDTH-1:0] o_rdAddr,
    output logic [ADDR_WIDTH:0]   o_wrPtrGray,
    output logic [ADDR_WIDTH:0]   o_rdPtrGray,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostFull,
    output logic                  o_almostEmpty
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    // Full means the write pointer is exactly one lap ahead of the read pointer. In Gray code
    // that is the read pointer with its two top bits inverted and the rest unchanged.
    localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);

    function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // State
    logic [PtrW-1:0] wr_bin_q,  wr_bin_d;
    logic [PtrW-1:0] rd_bin_q,  rd_bin_d;
    logic [PtrW-1:0] wr_gray_q, wr_gray_d;
    logic [PtrW-1:0] rd_gray_q, rd_gray_d;
    logic [PtrW-1:0] count_q,   count_d;
    logic            full_q,    full_d;
    logic            empty_q,   empty_d;

    // Accepted transfers. Flush suppresses both so no partial pointer update can happen.
    logic push;
    logic pop;

    always_comb begin
        push = i_wrValid & ~full_q & ~i_flush;
        pop  = i_rdReady & ~empty_q & ~i_flush;
    end

    // Next-state pointers, Gray codes, fill level and flags
    always_comb begin
        wr_bin_d = wr_bin_q;
        rd_bin_d = rd_bin_q;

        if (i_flush) begin
            wr_bin_d = '0;
            rd_bin_d = '0;
        end else begin
            if (push) begin
                wr_bin_d = wr_bin_q + PtrW'(1);
            end
            if (pop) begin
                rd_bin_d = rd_bin_q + PtrW'(1);
            end
        end

        wr_gray_d = bin2gray(wr_bin_d);
        rd_gray_d = bin2gray(rd_bin_d);

        // Modulo subtraction handles pointer wrap-around without any special casing.
        count_d   = wr_bin_d - rd_bin_d;

        empty_d   = (wr_gray_d == rd_gray_d);
        full_d    = (wr_gray_d == (rd_gray_d ^ FullMask));
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            wr_gray_q <= '0;
            rd_gray_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            wr_gray_q <= wr_gray_d;
            rd_gray_q <= rd_gray_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

`ifdef FIFO_POINTER_CTRL_LEVEL_EN
    logic almost_full_q,  almost_full_d;
    logic almost_empty_q, almost_empty_d;

    always_comb begin
        almost_full_d  = (count_d >= PtrW'(ALMOST_FULL));
        almost_empty_d = (count_d <= PtrW'(ALMOST_EMPTY));
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign o_almostFull  = almost_full_q;
    assign o_almostEmpty = almost_empty_q;
`else
    // Thresholds are not used in this build; fold them into a sink so they stay referenced.
    logic unused_levels;
    assign unused_levels = ^{PtrW'(ALMOST_FULL), PtrW'(ALMOST_EMPTY)};

    assign o_almostFull  = 1'b0;
    assign o_almostEmpty = 1'b0;
`endif

    // Outputs
    assign o_wrReady   = ~full_q;
    assign o_rdValid   = ~empty_q;
    assign o_wrEnable  = push;
    assign o_wrAddr    = wr_bin_q[ADDR_WIDTH-1:0];
    assign o_rdAddr    = rd_bin_q[ADDR_WIDTH-1:0];
    assign o_wrPtrGray = wr_gray_q;
    assign o_rdPtrGray = rd_gray_q;
    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;

endmodule

// File: tb/tb_fifo_pointer_ctrl.sv
// Self-checking bench for fifo_pointer_ctrl (ADDR_WIDTH = 4, depth 16).
// The reference model holds the FIFO contents as a queue of RAM addresses; fill level,
// flags and pointer values are derived from that queue and two lap counters.

module tb_fifo_pointer_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LAPS  = 32;

`ifdef FIFO_POINTER_CTRL_LEVEL_EN
    localparam bit LvlEn = 1'b1;
`else
    localparam bit LvlEn = 1'b0;
`endif

    logic          i_clock   = 1'b0;
    logic          i_reset   = 1'b1;
    logic          i_flush   = 1'b0;
    logic          i_wrValid = 1'b0;
    logic          i_rdReady = 1'b0;
    logic          o_wrReady;
    logic          o_wrEnable;
    logic [AW-1:0] o_wrAddr;
    logic          o_rdValid;
    logic [AW-1:0] o_rdAddr;
    logic [AW:0]   o_wrPtrGray;
    logic [AW:0]   o_rdPtrGray;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_almostFull;
    logic          o_almostEmpty;

    fifo_pointer_ctrl #(
        .ADDR_WIDTH  (AW),
        .ALMOST_FULL (12),
        .ALMOST_EMPTY(2)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_wrValid    (i_wrValid),
        .o_wrReady    (o_wrReady),
        .o_wrEnable   (o_wrEnable),
        .o_wrAddr     (o_wrAddr),
        .i_rdReady    (i_rdReady),
        .o_rdValid    (o_rdValid),
        .o_rdAddr     (o_rdAddr),
        .o_wrPtrGray  (o_wrPtrGray),
        .o_rdPtrGray  (o_rdPtrGray),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_almostFull (o_almostFull),
        .o_almostEmpty(o_almostEmpty)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    int q[$];       // RAM addresses of words currently held, oldest first
    int m_wr = 0;   // write position, counts modulo 2*DEPTH
    int m_rd = 0;   // read position, counts modulo 2*DEPTH
    int m_cnt = 0;

    // Per-cycle observations and expectations
    logic obs_we;
    logic [AW-1:0] obs_wa;
    logic [AW-1:0] obs_ra;
    logic exp_we;
    logic pop_acc;
    int   exp_wa;
    int   head;

    function automatic logic [AW:0] gray(input int p);
        logic [AW:0] b;
        b = (AW+1)'(p);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [21:0] exp_state();
        return {exp_we, (AW+1)'(m_cnt), m_cnt == DEPTH, m_cnt == 0, m_cnt != DEPTH, m_cnt != 0,
                gray(m_wr), gray(m_rd), LvlEn && (m_cnt >= 12), LvlEn && (m_cnt <= 2)};
    endfunction

    function automatic logic [21:0] got_state();
        return {obs_we, o_count, o_full, o_empty, o_wrReady, o_rdValid,
                o_wrPtrGray, o_rdPtrGray, o_almostFull, o_almostEmpty};
    endfunction

    // One clock: drive inputs, observe combinational outputs, clock, update the model.
    // Returns at posedge+1 with inputs idle.
    task automatic cycle(input logic wv, input logic rr, input logic fl);
        i_wrValid = wv;
        i_rdReady = rr;
        i_flush   = fl;
        #2;
        obs_we  = o_wrEnable;
        obs_wa  = o_wrAddr;
        obs_ra  = o_rdAddr;
        exp_we  = wv && (m_cnt < DEPTH) && !fl;
        pop_acc = rr && (m_cnt > 0) && !fl;
        exp_wa  = m_wr % DEPTH;
        head    = -1;
        @(posedge i_clock);
        #1;
        if (fl) begin
            q.delete();
            m_wr = 0;
            m_rd = 0;
        end else begin
            if (pop_acc) begin
                head = q.pop_front();
                m_rd = (m_rd + 1) % LAPS;
            end
            if (exp_we) begin
                q.push_back(exp_wa);
                m_wr = (m_wr + 1) % LAPS;
            end
        end
        m_cnt = q.size();
        i_wrValid = 1'b0;
        i_rdReady = 1'b0;
        i_flush   = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_wr  = 0;
        m_rd  = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_cmp++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_cmp++; if (o_wrReady !== 1'b1) begin n_bad++; $display("FAIL reset_wrReady: got %b want 1", o_wrReady); end
        n_cmp++; if (o_rdValid !== 1'b0) begin n_bad++; $display("FAIL reset_rdValid: got %b want 0", o_rdValid); end
        n_cmp++; if (o_wrEnable !== 1'b0) begin n_bad++; $display("FAIL reset_wrEnable: got %b want 0", o_wrEnable); end
        n_cmp++; if (o_wrPtrGray !== 5'b00000 || o_rdPtrGray !== 5'b00000) begin
            n_bad++; $display("FAIL reset_gray: got wr %b rd %b want 00000", o_wrPtrGray, o_rdPtrGray);
        end
        n_cmp++; if (o_almostFull !== 1'b0 || o_almostEmpty !== LvlEn) begin
            n_bad++; $display("FAIL reset_almost: got af %b ae %b want af 0 ae %b",
                              o_almostFull, o_almostEmpty, LvlEn);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++; if (obs_we !== 1'b1 || obs_wa !== AW'(i - 1)) begin
                n_bad++; $display("FAIL fill_write[%0d]: got we %b addr %0d want we 1 addr %0d",
                                  i, obs_we, obs_wa, i - 1);
            end
            n_cmp++; if (o_count !== 5'(i) || o_full !== (i == DEPTH)) begin
                n_bad++; $display("FAIL fill_count[%0d]: got count %0d full %b want count %0d full %b",
                                  i, o_count, o_full, i, i == DEPTH);
            end
            n_cmp++; if (o_almostFull !== (LvlEn && i >= 12)) begin
                n_bad++; $display("FAIL fill_almostFull[%0d]: got %b want %b", i, o_almostFull,
                                  LvlEn && i >= 12);
            end
        end
        n_cmp++; if (o_wrPtrGray !== 5'b11000 || o_wrReady !== 1'b0) begin
            n_bad++; $display("FAIL fill_full_state: got gray %b wrReady %b want 11000 0",
                              o_wrPtrGray, o_wrReady);
        end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (obs_we !== 1'b0 || o_count !== 5'd16) begin
            n_bad++; $display("FAIL fill_overflow: got we %b count %0d want we 0 count 16", obs_we, o_count);
        end
    endtask

    task automatic test_full_simul();
        cycle(1'b1, 1'b1, 1'b0);
        n_cmp++; if (obs_we !== 1'b0 || o_count !== 5'd15 || o_full !== 1'b0 || o_rdAddr !== 4'd1) begin
            n_bad++; $display("FAIL full_simul: got we %b count %0d full %b rdAddr %0d want 0 15 0 1",
                              obs_we, o_count, o_full, o_rdAddr);
        end
        n_cmp++; if (got_state() !== exp_state()) begin
            n_bad++; $display("FAIL full_simul_state: got %h want %h", got_state(), exp_state());
        end
    endtask

    task automatic test_empty_simul();
        cycle(1'b0, 1'b0, 1'b1);
        n_cmp++; if (o_count !== 5'd0 || o_empty !== 1'b1 || o_wrPtrGray !== 5'd0 || o_rdPtrGray !== 5'd0) begin
            n_bad++; $display("FAIL drain_flush: got count %0d empty %b wr %b rd %b want 0 1 0 0",
                              o_count, o_empty, o_wrPtrGray, o_rdPtrGray);
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_cmp++; if (obs_we !== 1'b1 || o_count !== 5'd1 || o_rdPtrGray !== 5'd0 || o_rdValid !== 1'b1) begin
            n_bad++; $display("FAIL empty_simul: got we %b count %0d rdGray %b rdValid %b want 1 1 0 1",
                              obs_we, o_count, o_rdPtrGray, o_rdValid);
        end
    endtask

    task automatic test_wrap();
        logic [AW:0] pw;
        logic [AW:0] pr;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            pw = o_wrPtrGray;
            pr = o_rdPtrGray;
            cycle(1'b1, 1'b1, 1'b0);
            n_cmp++; if ($countones(pw ^ o_wrPtrGray) != 1 || $countones(pr ^ o_rdPtrGray) != 1) begin
                n_bad++; $display("FAIL wrap_gray_step[%0d]: got wr %b->%b rd %b->%b want 1-bit steps",
                                  i, pw, o_wrPtrGray, pr, o_rdPtrGray);
            end
            n_cmp++; if (got_state() !== exp_state() || int'(obs_ra) != head) begin
                n_bad++; $display("FAIL wrap_state[%0d]: got %h rdAddr %0d want %h rdAddr %0d",
                                  i, got_state(), obs_ra, exp_state(), head);
            end
        end
    endtask

    task automatic test_flush();
        while (m_cnt < 7) cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_count !== 5'd7) begin
            n_bad++; $display("FAIL flush_precount: got %0d want 7", o_count);
        end
        cycle(1'b1, 1'b0, 1'b1);
        n_cmp++; if (obs_we !== 1'b0 || o_count !== 5'd0 || o_empty !== 1'b1 ||
                     o_wrPtrGray !== 5'd0 || o_rdPtrGray !== 5'd0 || o_wrAddr !== 4'd0) begin
            n_bad++; $display("FAIL flush: got we %b count %0d empty %b wr %b rd %b want 0 0 1 0 0",
                              obs_we, o_count, o_empty, o_wrPtrGray, o_rdPtrGray);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        // Assert reset between edges; state must clear without a clock edge.
        i_reset = 1'b1;
        #2;
        n_cmp++; if (o_count !== 5'd0 || o_empty !== 1'b1 || o_wrPtrGray !== 5'd0 || o_wrAddr !== 4'd0) begin
            n_bad++; $display("FAIL async_reset: got count %0d empty %b wrGray %b wrAddr %0d want 0 1 0 0",
                              o_count, o_empty, o_wrPtrGray, o_wrAddr);
        end
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        n_cmp++; if (got_state() !== exp_state()) begin
            n_bad++; $display("FAIL async_reset_idle: got %h want %h", got_state(), exp_state());
        end
    endtask

    task automatic test_random();
        logic wv;
        logic rr;
        logic fl;
        for (int i = 0; i < 600; i++) begin
            // Alternate fill-biased and drain-biased phases so both flag edges are exercised.
            if (((i / 50) % 2) == 0) begin
                wv = ($urandom_range(3) != 0);
                rr = ($urandom_range(3) == 0);
            end else begin
                wv = ($urandom_range(3) == 0);
                rr = ($urandom_range(3) != 0);
            end
            fl = ($urandom_range(59) == 0);
            cycle(wv, rr, fl);
            n_cmp++; if (got_state() !== exp_state()) begin
                n_bad++; $display("FAIL random_state[%0d]: got %h want %h", i, got_state(), exp_state());
            end
            if (exp_we) begin
                n_cmp++; if (int'(obs_wa) != exp_wa) begin
                    n_bad++; $display("FAIL random_wrAddr[%0d]: got %0d want %0d", i, obs_wa, exp_wa);
                end
            end
            if (pop_acc) begin
                n_cmp++; if (int'(obs_ra) != head) begin
                    n_bad++; $display("FAIL random_rdAddr[%0d]: got %0d want %0d", i, obs_ra, head);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clock);
        #1;
        test_reset();
        i_reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        test_fill();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_pointer_ctrl.md
Name: fifo_pointer_ctrl

Overview:
Single-clock FIFO controller that sequences a pair of Gray-coded read/write pointers around an external dual-port RAM of 2^ADDR_WIDTH words.
- Accepts push/pop requests through valid/ready handshakes.
- Drives RAM write enable and read/write addresses.
- Keeps registered full/empty/count status.
- Exports both pointers in Gray code, so a later dual-clock FIFO can reuse the same pointer format unchanged.
- Sits between a producer/consumer pair and a generic RAM block.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH (minimum 2).
- ALMOST_FULL, 12, fill level at or above which o_almostFull asserts (only with the optional feature).
- ALMOST_EMPTY, 2, fill level at or below which o_almostEmpty asserts (only with the optional feature).

Ports:
- i_clock  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_flush  input  1  synchronous clear of both pointers.
- i_wrValid  input  1  producer offers a word.
- o_wrReady  output  1  FIFO can accept a word (= not full).
- o_wrEnable  output  1  RAM write strobe (= i_wrValid & o_wrReady & ~i_flush).
- o_wrAddr  output  ADDR_WIDTH  RAM write address.
- i_rdReady  input  1  consumer takes the head word.
- o_rdValid  output  1  head word valid (= not empty).
- o_rdAddr  output  ADDR_WIDTH  RAM read address of the head word.
- o_wrPtrGray  output  ADDR_WIDTH+1  write pointer, Gray code.
- o_rdPtrGray  output  ADDR_WIDTH+1  read pointer, Gray code.
- o_count  output  ADDR_WIDTH+1  current fill level, 0..2^ADDR_WIDTH.
- o_full  output  1  registered full flag.
- o_empty  output  1  registered empty flag.
- o_almostFull  output  1  optional feature only.
- o_almostEmpty  output  1  optional feature only.

Behaviour:
- Reset (asynchronous, i_reset=1):
  - Binary and Gray pointers = 0; o_count = 0.
  - o_empty = 1, o_full = 0, o_wrReady = 1, o_rdValid = 0, o_wrEnable = 0.
  - o_almostEmpty = 1, o_almostFull = 0.
  - Reset mid-operation discards contents; no partial pointer update is allowed.
- Pointers:
  - Each pointer is ADDR_WIDTH+1 bits, binary internally.
  - Gray form = bin ^ (bin >> 1), registered in the same cycle as the binary value.
  - Addresses are the binary pointer's low ADDR_WIDTH bits.
  - Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- Push accepted = i_wrValid & o_wrReady & ~i_flush. Write pointer +1 at the next edge; the RAM writes at the current o_wrAddr in the same cycle.
- Pop accepted = i_rdReady & o_rdValid & ~i_flush. Read pointer +1 at the next edge; o_rdAddr points to the next word one cycle after the pop.
- Flags:
  - Computed from next-state Gray pointers and registered, so they have no combinational path from the inputs.
  - Empty: wrGrayNext == rdGrayNext.
  - Full: wrGrayNext == {~rdGrayNext[MSB:MSB-1], rdGrayNext[MSB-2:0]}.
- o_count = wrBin - rdBin, registered, updated in the same edge as the pointers.
- Simultaneous push and pop:
  - Not full and not empty: both accepted; count unchanged; flags unchanged.
  - Full: pop accepted, push rejected (o_wrReady=0); next cycle count = depth-1.
  - Empty: push accepted, pop ignored (o_rdValid=0); next cycle count = 1 and o_rdValid = 1.
- Push while full and pop while empty: ignored; pointers and count are held.
- i_flush:
  - Highest priority after reset.
  - Next edge: both pointers = 0, count = 0, o_empty = 1.
  - o_wrEnable is forced 0 during the flush cycle.
- Latency: a word written in cycle N is visible at o_rdValid in cycle N+1 (external RAM must have an asynchronous or write-through read).

Optional Feature:
- Macro: FIFO_POINTER_CTRL_LEVEL_EN.
- Defined:
  - o_almostFull = registered (countNext >= ALMOST_FULL).
  - o_almostEmpty = registered (countNext <= ALMOST_EMPTY).
  - Both follow the same reset and flush rules as o_full and o_empty.
- Undefined: both ports are tied to 0, the threshold comparators are not built, and the parameters are ignored.

Test Plan:
- Reset then idle, ADDR_WIDTH=4 -> o_empty=1, o_full=0, o_count=0, o_wrReady=1, o_rdValid=0, both Gray pointers 5'b00000.
- 16 consecutive pushes, no pops -> o_count steps 1..16, o_full=1 after edge 16, o_wrPtrGray=5'b11000, o_wrReady=0; 17th push gives o_wrEnable=0 and count stays 16.
- Fill to 16, then drive push and pop in the same cycle -> pop accepted, push rejected, count=15, o_full=0, o_rdAddr=1.
- From empty, push and pop in the same cycle -> count=1, rdPtr unchanged (0), o_rdValid=1 the next cycle.
- 40 pushes interleaved with pops (count kept at 3) -> pointers wrap past 31 to 0; every Gray step differs by exactly 1 bit; flags stay correct.
- Count=7, then assert i_flush together with push -> next cycle pointers=0, count=0, o_empty=1, o_wrEnable=0 during the flush cycle.
- With FIFO_POINTER_CTRL_LEVEL_EN defined, ALMOST_FULL=12 -> o_almostFull rises on the edge where count becomes 12 and falls when count drops to 11.
